// File: rtl/tcp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tcp_pkg
// Purpose : Shared TCP offload types and widths. Carries the flow id and
//           RX payload pointer widths, the consume-engine state encoding and
//           the consume response record.
// Revision: 1.0 - initial release of rx_head_ptr_update support types
// ============================================================================
package tcp_pkg;

   localparam int FLOWID_W         = 8;
   localparam int RX_PAYLOAD_PTR_W = 16;

   // Consume engine states (rx_head_ptr_update)
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_RESP = 3'd2,
      CALC    = 3'd3,
      WR      = 3'd4,
      RESP    = 3'd5
   } rx_head_upd_state_e;

   // Consume result; pointers carry the wrap bit as MSB
   typedef struct packed {
      logic                        ok;
      logic [RX_PAYLOAD_PTR_W:0]   avail;
      logic [RX_PAYLOAD_PTR_W:0]   new_head;
   } rx_consume_resp_struct;

endpackage
`default_nettype wire

// File: rtl/rx_head_upd_datap.sv
`default_nettype none
// ============================================================================
// Module  : rx_head_upd_datap
// Purpose : Datapath of the RX consume engine. Holds the latched request,
//           the head/commit pointers read from the pointer store, and the
//           registered consume result computed in CALC.
// Ports   : req_ld/req_flowid/req_len   - latch the accepted request
//           head_ld/head_data           - latch head pointer read response
//           commit_ld/commit_data       - latch commit pointer read response
//           calc_ld                     - register the consume result
//           flowid                      - latched flow id
//           calc_ok/calc_len_nz         - combinational decision inputs to FSM
//           resp                        - registered ok/avail/new_head
// Note    : The response record is sized by tcp_pkg::RX_PAYLOAD_PTR_W, so
//           PTR_W_P is expected to stay at its package default.
// Revision: 1.0 - initial release
// ============================================================================
module rx_head_upd_datap
   import tcp_pkg::*;
#(
   parameter int FLOWID_W_P = FLOWID_W,
   parameter int PTR_W_P    = RX_PAYLOAD_PTR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_ld,
   input  logic [FLOWID_W_P-1:0]   req_flowid,
   input  logic [PTR_W_P:0]        req_len,
   input  logic                    head_ld,
   input  logic [PTR_W_P:0]        head_data,
   input  logic                    commit_ld,
   input  logic [PTR_W_P:0]        commit_data,
   input  logic                    calc_ld,
   output logic [FLOWID_W_P-1:0]   flowid,
   output logic                    calc_ok,
   output logic                    calc_len_nz,
   output rx_consume_resp_struct   resp
);

   // Largest legal distance between commit and head: a completely full buffer
   localparam logic [PTR_W_P:0] C_CAP = {1'b1, {PTR_W_P{1'b0}}};

   logic [FLOWID_W_P-1:0]   r_flowid;
   logic [PTR_W_P:0]        r_len;
   logic [PTR_W_P:0]        r_head;
   logic [PTR_W_P:0]        r_commit;
   rx_consume_resp_struct   r_resp;

   logic [PTR_W_P:0]        w_avail;
   logic                    w_ok;
   logic [PTR_W_P:0]        w_new_head;

   // Modulo arithmetic over the wrap bit handles buffer wrap without special
   // cases. A distance above C_CAP can only come from a corrupt pointer pair,
   // so the avail bound rejects those along with over-consumes.
   always_comb begin
      w_avail    = r_commit - r_head;
      w_ok       = (w_avail <= C_CAP) && (r_len <= w_avail);
      w_new_head = w_ok ? (r_head + r_len) : r_head;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flowid <= '0;
         r_len    <= '0;
         r_head   <= '0;
         r_commit <= '0;
         r_resp   <= '0;
      end else begin
         if (req_ld) begin
            r_flowid <= req_flowid;
            r_len    <= req_len;
         end
         if (head_ld) begin
            r_head <= head_data;
         end
         if (commit_ld) begin
            r_commit <= commit_data;
         end
         if (calc_ld) begin
            r_resp.ok       <= w_ok;
            r_resp.avail    <= w_avail;
            r_resp.new_head <= w_new_head;
         end
      end
   end

   assign flowid      = r_flowid;
   assign calc_ok     = w_ok;
   assign calc_len_nz = |r_len;
   assign resp        = r_resp;

endmodule
`default_nettype wire

// File: rtl/rx_head_ptr_update.sv
`default_nettype none
// ============================================================================
// Module  : rx_head_ptr_update
// Purpose : Application-side consume engine for the RX payload buffer.
//           Reads a flow's head and commit pointers, checks the requested
//           length against committed unread bytes, advances the head pointer
//           when it fits and returns an ok/err response. One request in
//           flight at a time.
// Ports   : consume_req_*            - consume request (flow id, length)
//           consume_resp_*           - ok flag, avail bytes, resulting head
//           head_ptr_rd1_req/resp_*  - head pointer read port of the store
//           commit_ptr_rd1_req/resp_*- commit pointer read port of the store
//           head_ptr_wr_req_*        - head pointer write port of the store
//           stat_ok_cnt/stat_err_cnt - saturating response counters, present
//                                      only with RX_HEAD_PTR_UPDATE_STATS_EN
// Reset   : rst is asynchronous, active-low.
// Revision: 1.0 - initial release
// ============================================================================
module rx_head_ptr_update
   import tcp_pkg::*;
#(
   parameter int FLOWID_W_P = FLOWID_W,
   parameter int PTR_W_P    = RX_PAYLOAD_PTR_W
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef RX_HEAD_PTR_UPDATE_STATS_EN
   output logic [31:0]             stat_ok_cnt,
   output logic [31:0]             stat_err_cnt,
`endif
   input  logic                    consume_req_val,
   input  logic [FLOWID_W_P-1:0]   consume_req_flowid,
   input  logic [PTR_W_P:0]        consume_req_len,
   output logic                    consume_req_rdy,
   output logic                    consume_resp_val,
   output logic                    consume_resp_ok,
   output logic [PTR_W_P:0]        consume_resp_avail,
   output logic [PTR_W_P:0]        consume_resp_new_head,
   input  logic                    consume_resp_rdy,
   output logic                    head_ptr_rd1_req_val,
   output logic [FLOWID_W_P-1:0]   head_ptr_rd1_req_addr,
   input  logic                    head_ptr_rd1_req_rdy,
   input  logic                    head_ptr_rd1_resp_val,
   input  logic [PTR_W_P:0]        head_ptr_rd1_resp_data,
   output logic                    head_ptr_rd1_resp_rdy,
   output logic                    commit_ptr_rd1_req_val,
   output logic [FLOWID_W_P-1:0]   commit_ptr_rd1_req_addr,
   input  logic                    commit_ptr_rd1_req_rdy,
   input  logic                    commit_ptr_rd1_resp_val,
   input  logic [PTR_W_P:0]        commit_ptr_rd1_resp_data,
   output logic                    commit_ptr_rd1_resp_rdy,
   output logic                    head_ptr_wr_req_val,
   output logic [FLOWID_W_P-1:0]   head_ptr_wr_req_addr,
   output logic [PTR_W_P:0]        head_ptr_wr_req_data,
   input  logic                    head_ptr_wr_req_rdy
);

   rx_head_upd_state_e      r_state;
   rx_head_upd_state_e      w_state_nxt;

   // Per-port progress flags: the two reads are independent handshakes
   logic                    r_head_sent;
   logic                    r_commit_sent;
   logic                    r_head_got;
   logic                    r_commit_got;

   logic                    w_req_ld;
   logic                    w_head_ld;
   logic                    w_commit_ld;
   logic                    w_calc_ld;
   logic                    w_head_req_done;
   logic                    w_commit_req_done;
   logic                    w_head_resp_done;
   logic                    w_commit_resp_done;

   logic [FLOWID_W_P-1:0]   w_flowid;
   logic                    w_calc_ok;
   logic                    w_calc_len_nz;
   rx_consume_resp_struct   w_resp;

   rx_head_upd_datap #(
      .FLOWID_W_P  (FLOWID_W_P),
      .PTR_W_P     (PTR_W_P)
   ) u_datap (
      .clk         (clk),
      .rst         (rst),
      .req_ld      (w_req_ld),
      .req_flowid  (consume_req_flowid),
      .req_len     (consume_req_len),
      .head_ld     (w_head_ld),
      .head_data   (head_ptr_rd1_resp_data),
      .commit_ld   (w_commit_ld),
      .commit_data (commit_ptr_rd1_resp_data),
      .calc_ld     (w_calc_ld),
      .flowid      (w_flowid),
      .calc_ok     (w_calc_ok),
      .calc_len_nz (w_calc_len_nz),
      .resp        (w_resp)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Read handshake tracking; flags are cleared every time IDLE is visited
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head_sent   <= 1'b0;
         r_commit_sent <= 1'b0;
         r_head_got    <= 1'b0;
         r_commit_got  <= 1'b0;
      end else if (r_state == IDLE) begin
         r_head_sent   <= 1'b0;
         r_commit_sent <= 1'b0;
         r_head_got    <= 1'b0;
         r_commit_got  <= 1'b0;
      end else begin
         if (head_ptr_rd1_req_val && head_ptr_rd1_req_rdy) begin
            r_head_sent <= 1'b1;
         end
         if (commit_ptr_rd1_req_val && commit_ptr_rd1_req_rdy) begin
            r_commit_sent <= 1'b1;
         end
         if (w_head_ld) begin
            r_head_got <= 1'b1;
         end
         if (w_commit_ld) begin
            r_commit_got <= 1'b1;
         end
      end
   end

   assign w_head_req_done    = r_head_sent   || head_ptr_rd1_req_rdy;
   assign w_commit_req_done  = r_commit_sent || commit_ptr_rd1_req_rdy;
   assign w_head_ld          = head_ptr_rd1_resp_val   && head_ptr_rd1_resp_rdy;
   assign w_commit_ld        = commit_ptr_rd1_resp_val && commit_ptr_rd1_resp_rdy;
   assign w_head_resp_done   = r_head_got   || w_head_ld;
   assign w_commit_resp_done = r_commit_got || w_commit_ld;
   assign w_req_ld           = consume_req_val && consume_req_rdy;

   // ---------------------------------------------------------------------
   // Next state and handshake outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt             = r_state;
      consume_req_rdy         = 1'b0;
      consume_resp_val        = 1'b0;
      head_ptr_rd1_req_val    = 1'b0;
      commit_ptr_rd1_req_val  = 1'b0;
      head_ptr_rd1_resp_rdy   = 1'b0;
      commit_ptr_rd1_resp_rdy = 1'b0;
      head_ptr_wr_req_val     = 1'b0;
      w_calc_ld               = 1'b0;

      case (r_state)
         IDLE: begin
            consume_req_rdy = 1'b1;
            if (consume_req_val) begin
               w_state_nxt = RD_REQ;
            end
         end
         RD_REQ: begin
            head_ptr_rd1_req_val   = !r_head_sent;
            commit_ptr_rd1_req_val = !r_commit_sent;
            if (w_head_req_done && w_commit_req_done) begin
               w_state_nxt = RD_RESP;
            end
         end
         RD_RESP: begin
            head_ptr_rd1_resp_rdy   = !r_head_got;
            commit_ptr_rd1_resp_rdy = !r_commit_got;
            if (w_head_resp_done && w_commit_resp_done) begin
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            w_calc_ld = 1'b1;
            // A zero-length consume succeeds without touching the store
            if (w_calc_ok && w_calc_len_nz) begin
               w_state_nxt = WR;
            end else begin
               w_state_nxt = RESP;
            end
         end
         WR: begin
            head_ptr_wr_req_val = 1'b1;
            if (head_ptr_wr_req_rdy) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            consume_resp_val = 1'b1;
            if (consume_resp_rdy) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign head_ptr_rd1_req_addr   = w_flowid;
   assign commit_ptr_rd1_req_addr = w_flowid;
   assign head_ptr_wr_req_addr    = w_flowid;
   assign head_ptr_wr_req_data    = w_resp.new_head;
   assign consume_resp_ok         = w_resp.ok;
   assign consume_resp_avail      = w_resp.avail;
   assign consume_resp_new_head   = w_resp.new_head;

`ifdef RX_HEAD_PTR_UPDATE_STATS_EN
   // ---------------------------------------------------------------------
   // Saturating response counters, stepped on the response handshake
   // ---------------------------------------------------------------------
   logic [31:0] r_ok_cnt;
   logic [31:0] r_err_cnt;
   logic        w_resp_hs;

   assign w_resp_hs = consume_resp_val && consume_resp_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (w_resp_hs) begin
         if (w_resp.ok) begin
            if (r_ok_cnt != 32'hFFFF_FFFF) begin
               r_ok_cnt <= r_ok_cnt + 32'd1;
            end
         end else begin
            if (r_err_cnt != 32'hFFFF_FFFF) begin
               r_err_cnt <= r_err_cnt + 32'd1;
            end
         end
      end
   end

   assign stat_ok_cnt  = r_ok_cnt;
   assign stat_err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_head_ptr_update.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_head_ptr_update
// Purpose : Self-checking bench for rx_head_ptr_update. A small pointer-store
//           model answers reads from st_head/st_commit and accepts writes
//           with configurable delays; directed vectors and corner sequences
//           compare responses against hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rx_head_ptr_update;

   localparam int FW = 8;
   localparam int PW = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;

   logic            consume_req_val;
   logic [FW-1:0]   consume_req_flowid;
   logic [PW:0]     consume_req_len;
   logic            consume_req_rdy;
   logic            consume_resp_val;
   logic            consume_resp_ok;
   logic [PW:0]     consume_resp_avail;
   logic [PW:0]     consume_resp_new_head;
   logic            consume_resp_rdy;
   logic            head_ptr_rd1_req_val;
   logic [FW-1:0]   head_ptr_rd1_req_addr;
   logic            head_ptr_rd1_req_rdy;
   logic            head_ptr_rd1_resp_val;
   logic [PW:0]     head_ptr_rd1_resp_data;
   logic            head_ptr_rd1_resp_rdy;
   logic            commit_ptr_rd1_req_val;
   logic [FW-1:0]   commit_ptr_rd1_req_addr;
   logic            commit_ptr_rd1_req_rdy;
   logic            commit_ptr_rd1_resp_val;
   logic [PW:0]     commit_ptr_rd1_resp_data;
   logic            commit_ptr_rd1_resp_rdy;
   logic            head_ptr_wr_req_val;
   logic [FW-1:0]   head_ptr_wr_req_addr;
   logic [PW:0]     head_ptr_wr_req_data;
   logic            head_ptr_wr_req_rdy;
`ifdef RX_HEAD_PTR_UPDATE_STATS_EN
   logic [31:0]     stat_ok_cnt;
   logic [31:0]     stat_err_cnt;
`endif

   rx_head_ptr_update #(
      .FLOWID_W_P (FW),
      .PTR_W_P    (PW)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
`ifdef RX_HEAD_PTR_UPDATE_STATS_EN
      .stat_ok_cnt              (stat_ok_cnt),
      .stat_err_cnt             (stat_err_cnt),
`endif
      .consume_req_val          (consume_req_val),
      .consume_req_flowid       (consume_req_flowid),
      .consume_req_len          (consume_req_len),
      .consume_req_rdy          (consume_req_rdy),
      .consume_resp_val         (consume_resp_val),
      .consume_resp_ok          (consume_resp_ok),
      .consume_resp_avail       (consume_resp_avail),
      .consume_resp_new_head    (consume_resp_new_head),
      .consume_resp_rdy         (consume_resp_rdy),
      .head_ptr_rd1_req_val     (head_ptr_rd1_req_val),
      .head_ptr_rd1_req_addr    (head_ptr_rd1_req_addr),
      .head_ptr_rd1_req_rdy     (head_ptr_rd1_req_rdy),
      .head_ptr_rd1_resp_val    (head_ptr_rd1_resp_val),
      .head_ptr_rd1_resp_data   (head_ptr_rd1_resp_data),
      .head_ptr_rd1_resp_rdy    (head_ptr_rd1_resp_rdy),
      .commit_ptr_rd1_req_val   (commit_ptr_rd1_req_val),
      .commit_ptr_rd1_req_addr  (commit_ptr_rd1_req_addr),
      .commit_ptr_rd1_req_rdy   (commit_ptr_rd1_req_rdy),
      .commit_ptr_rd1_resp_val  (commit_ptr_rd1_resp_val),
      .commit_ptr_rd1_resp_data (commit_ptr_rd1_resp_data),
      .commit_ptr_rd1_resp_rdy  (commit_ptr_rd1_resp_rdy),
      .head_ptr_wr_req_val      (head_ptr_wr_req_val),
      .head_ptr_wr_req_addr     (head_ptr_wr_req_addr),
      .head_ptr_wr_req_data     (head_ptr_wr_req_data),
      .head_ptr_wr_req_rdy      (head_ptr_wr_req_rdy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------------
   // Pointer store model
   // ---------------------------------------------------------------------
   logic [PW:0]   st_head   = '0;
   logic [PW:0]   st_commit = '0;
   int            head_rdy_dly = 0;
   int            wr_rdy_dly   = 0;
   int            head_wait    = 0;
   int            wr_wait      = 0;
   int            head_acc     = 0;
   int            commit_acc   = 0;
   int            wr_cnt       = 0;
   int            wr_unstable  = 0;
   logic [PW:0]   wr_data_last = '0;
   logic [FW-1:0] wr_addr_last = '0;
   logic [FW-1:0] head_addr_last = '0;
   logic          wr_val_q  = 1'b0;
   logic [PW:0]   wr_data_q = '0;
   logic [FW-1:0] wr_addr_q = '0;

   assign head_ptr_rd1_req_rdy     = (head_wait >= head_rdy_dly);
   assign commit_ptr_rd1_req_rdy   = 1'b1;
   assign head_ptr_rd1_resp_val    = 1'b1;
   assign head_ptr_rd1_resp_data   = st_head;
   assign commit_ptr_rd1_resp_val  = 1'b1;
   assign commit_ptr_rd1_resp_data = st_commit;
   assign head_ptr_wr_req_rdy      = (wr_wait >= wr_rdy_dly);

   always @(posedge clk) begin
      if (head_ptr_rd1_req_val && !head_ptr_rd1_req_rdy) head_wait <= head_wait + 1;
      else if (!head_ptr_rd1_req_val)                     head_wait <= 0;
      if (head_ptr_wr_req_val && !head_ptr_wr_req_rdy)    wr_wait <= wr_wait + 1;
      else if (!head_ptr_wr_req_val)                      wr_wait <= 0;
      if (head_ptr_rd1_req_val && head_ptr_rd1_req_rdy) begin
         head_acc       <= head_acc + 1;
         head_addr_last <= head_ptr_rd1_req_addr;
      end
      if (commit_ptr_rd1_req_val && commit_ptr_rd1_req_rdy) commit_acc <= commit_acc + 1;
      if (head_ptr_wr_req_val && head_ptr_wr_req_rdy) begin
         wr_cnt       <= wr_cnt + 1;
         wr_data_last <= head_ptr_wr_req_data;
         wr_addr_last <= head_ptr_wr_req_addr;
      end
      if (head_ptr_wr_req_val && wr_val_q &&
          (head_ptr_wr_req_data != wr_data_q || head_ptr_wr_req_addr != wr_addr_q))
         wr_unstable <= wr_unstable + 1;
      wr_val_q  <= head_ptr_wr_req_val;
      wr_data_q <= head_ptr_wr_req_data;
      wr_addr_q <= head_ptr_wr_req_addr;
   end

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one consume and collect the response. Latency counts clock edges
   // from the accepting edge (inclusive) until resp_val is visible.
   task automatic run_op(input logic [FW-1:0] f, input logic [PW:0] l, input int hold,
                         output int lat, output logic ok, output logic [PW:0] av,
                         output logic [PW:0] nh, output int unstable);
      int guard;
      unstable = 0;
      @(negedge clk);
      consume_req_flowid = f;
      consume_req_len    = l;
      consume_req_val    = 1'b1;
      guard = 0;
      while (!consume_req_rdy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      consume_req_val = 1'b0;
      lat = 1;
      while (!consume_resp_val && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      ok = consume_resp_ok;
      av = consume_resp_avail;
      nh = consume_resp_new_head;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (!consume_resp_val || consume_resp_ok != ok ||
             consume_resp_avail != av || consume_resp_new_head != nh)
            unstable++;
      end
      consume_resp_rdy = 1'b1;
      @(posedge clk);
      #1;
      consume_resp_rdy = 1'b0;
   endtask

   typedef struct {
      logic [FW-1:0] flow;
      logic [PW:0]   head;
      logic [PW:0]   commit;
      logic [PW:0]   len;
      logic          ok;
      logic [PW:0]   avail;
      logic [PW:0]   nh;
      int            lat;
      int            writes;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        ok;
      logic [PW:0] av;
      logic [PW:0] nh;
      int          unst;
      int          w0, h0, c0, u0;

      //              flow    head      commit    len       ok    avail     new_head  lat writes
      vecs[0] = '{8'h03, 17'h00100, 17'h00400, 17'h00080, 1'b1, 17'h00300, 17'h00180, 5, 1};
      vecs[1] = '{8'h07, 17'h0FFF0, 17'h10010, 17'h00020, 1'b1, 17'h00020, 17'h10010, 5, 1};
      vecs[2] = '{8'h01, 17'h00000, 17'h00010, 17'h00011, 1'b0, 17'h00010, 17'h00000, 4, 0};
      vecs[3] = '{8'h02, 17'h05000, 17'h05000, 17'h00000, 1'b1, 17'h00000, 17'h05000, 4, 0};
      vecs[4] = '{8'hAA, 17'h00000, 17'h18000, 17'h00001, 1'b0, 17'h18000, 17'h00000, 4, 0};
      vecs[5] = '{8'h55, 17'h1FFF0, 17'h0FFF0, 17'h10000, 1'b1, 17'h10000, 17'h0FFF0, 5, 1};

      consume_req_val    = 1'b0;
      consume_req_flowid = '0;
      consume_req_len    = '0;
      consume_resp_rdy   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset wr_val", head_ptr_wr_req_val, 0);
      chk("reset resp_val", consume_resp_val, 0);
      chk("reset rd_vals", {head_ptr_rd1_req_val, commit_ptr_rd1_req_val}, 0);
      chk("reset resp_rdys", {head_ptr_rd1_resp_rdy, commit_ptr_rd1_resp_rdy}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post-reset req_rdy", consume_req_rdy, 1);
      chk("post-reset resp_new_head", consume_resp_new_head, 0);

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         st_head   = vecs[i].head;
         st_commit = vecs[i].commit;
         w0 = wr_cnt; h0 = head_acc; c0 = commit_acc;
         run_op(vecs[i].flow, vecs[i].len, 0, lat, ok, av, nh, unst);
         chk($sformatf("v%0d ok", i), ok, vecs[i].ok);
         chk($sformatf("v%0d avail", i), av, vecs[i].avail);
         chk($sformatf("v%0d new_head", i), nh, vecs[i].nh);
         chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d writes", i), wr_cnt - w0, vecs[i].writes);
         chk($sformatf("v%0d head reads", i), head_acc - h0, 1);
         chk($sformatf("v%0d commit reads", i), commit_acc - c0, 1);
         chk($sformatf("v%0d read addr", i), head_addr_last, vecs[i].flow);
         if (vecs[i].writes == 1) begin
            chk($sformatf("v%0d wr data", i), wr_data_last, vecs[i].nh);
            chk($sformatf("v%0d wr addr", i), wr_addr_last, vecs[i].flow);
         end
      end

      // Backpressure on head read, head write and response
      head_rdy_dly = 3;
      wr_rdy_dly   = 10;
      st_head      = 17'h00100;
      st_commit    = 17'h00400;
      w0 = wr_cnt; h0 = head_acc; c0 = commit_acc; u0 = wr_unstable;
      run_op(8'h3C, 17'h00080, 4, lat, ok, av, nh, unst);
      chk("bp resp seen", lat < 200, 1);
      chk("bp ok", ok, 1);
      chk("bp avail", av, 17'h00300);
      chk("bp new_head", nh, 17'h00180);
      chk("bp writes", wr_cnt - w0, 1);
      chk("bp wr data", wr_data_last, 17'h00180);
      chk("bp wr addr", wr_addr_last, 8'h3C);
      chk("bp wr stable", wr_unstable - u0, 0);
      chk("bp resp stable", unst, 0);
      chk("bp head reads", head_acc - h0, 1);
      chk("bp commit reads", commit_acc - c0, 1);
      head_rdy_dly = 0;
      wr_rdy_dly   = 0;

      // Reset while stalled in WR
      begin
         int guard;
         wr_rdy_dly = 1000;
         w0 = wr_cnt;
         @(negedge clk);
         consume_req_flowid = 8'h11;
         consume_req_len    = 17'h00080;
         consume_req_val    = 1'b1;
         @(posedge clk);
         #1;
         consume_req_val = 1'b0;
         guard = 0;
         while (!head_ptr_wr_req_val && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
         end
         chk("rst-mid reached WR", head_ptr_wr_req_val, 1);
         @(posedge clk);
         #3;
         rst = 1'b0;
         #1;
         chk("rst-mid wr_val", head_ptr_wr_req_val, 0);
         chk("rst-mid resp_val", consume_resp_val, 0);
         chk("rst-mid rd_vals", {head_ptr_rd1_req_val, commit_ptr_rd1_req_val}, 0);
         chk("rst-mid no write", wr_cnt - w0, 0);
         @(negedge clk);
         rst = 1'b1;
         wr_rdy_dly = 0;
         @(negedge clk);
         chk("rst-mid req_rdy", consume_req_rdy, 1);
         w0 = wr_cnt;
         run_op(8'h12, 17'h00080, 0, lat, ok, av, nh, unst);
         chk("after rst ok", ok, 1);
         chk("after rst new_head", nh, 17'h00180);
         chk("after rst latency", lat, 5);
         chk("after rst writes", wr_cnt - w0, 1);
         chk("after rst wr addr", wr_addr_last, 8'h12);
      end

`ifdef RX_HEAD_PTR_UPDATE_STATS_EN
      // Counters restart from reset: three accepted, one rejected
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("stats reset ok", stat_ok_cnt, 0);
      chk("stats reset err", stat_err_cnt, 0);
      for (int k = 0; k < 4; k++) begin
         st_head   = vecs[k].head;
         st_commit = vecs[k].commit;
         run_op(vecs[k].flow, vecs[k].len, 0, lat, ok, av, nh, unst);
      end
      @(negedge clk);
      chk("stats ok count", stat_ok_cnt, 3);
      chk("stats err count", stat_err_cnt, 1);
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
